fft_frame_sched: RTL and testbench
==================================

// Module: fft_frame_sched
// PURPOSE
//  Frame sequencer for the ADC->FFT->UART spectrum path; replaces the inline top-level FSM.
//  - Pulls N_POINTS ADC samples from the sample FIFO, converts offset-binary to signed and
//    streams them into the FFT core as one frame (tlast on final sample).
//  - Writes FFT output words into an external result RAM, then streams them MSB-byte-first
//    to the UART transmitter. Re-arms per frame (AUTO_REARM) or per start pulse.
// PARAMETERS
//  N_POINTS    1024  FFT frame length; power of two, >=8
//  IN_W        8     ADC sample width (offset-binary)
//  OUT_W       48    FFT output word width; multiple of 8
//  AUTO_REARM  0     1: start next frame immediately after UART dump; 0: wait for start
// PORTS
//  clk          in   1      single clock (FFT/UART domain); all ports synchronous to it
//  rst          in   1      synchronous, active-high reset
//  start        in   1      pulse: begin one frame (ignored unless state IDLE)
//  fifo_empty   in   1      sample FIFO empty
//  fifo_rd_en   out  1      FIFO read strobe; rd_data valid the following cycle
//  fifo_rd_data in   IN_W   FIFO read data
//  s_tvalid     out  1      FFT input valid
//  s_tready     in   1      FFT input ready
//  s_tdata      out  IN_W   signed sample = fifo_rd_data - 2^(IN_W-1) (MSB invert)
//  s_tlast      out  1      high with sample N_POINTS-1
//  m_tvalid     in   1      FFT output valid (no backpressure)
//  m_tdata      in   OUT_W  FFT output word
//  m_tlast      in   1      FFT output last
//  ram_we       out  1      result RAM write enable
//  ram_waddr    out  log2N  result RAM write address
//  ram_wdata    out  OUT_W  result RAM write data
//  ram_raddr    out  log2N  result RAM read address; read latency exactly 1 cycle
//  ram_rdata    in   OUT_W  result RAM read data
//  tx_start     out  1      one-cycle UART send pulse
//  tx_data      out  8      UART byte, stable from tx_start until tx_busy falls
//  tx_busy      in   1      UART busy
//  busy         out  1      high in every state except IDLE
//  frame_done   out  1      one-cycle pulse after last byte accepted
//  err_len      out  1      sticky: m_tlast count mismatch; cleared by rst or start
//  frame_cnt    out  16     completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0. Reset mid-frame aborts immediately, no flush.
//  - States: IDLE -> FEED (start, or AUTO_REARM) -> STORE (sample N-1 accepted) ->
//    SEND (m_tlast seen) -> IDLE (last byte issued, frame_done pulse).
//  - FEED: fifo_rd_en = !fifo_empty && (!s_tvalid || s_tready) && reads_issued<N. Output
//    register holds s_tdata/s_tvalid until s_tvalid&&s_tready; never drops or duplicates a
//    sample under any s_tready pattern. Exactly N reads per frame.
//  - STORE: each m_tvalid writes ram_waddr=out_cnt, same cycle (combinational we/addr/data
//    from registered count). m_tlast at out_cnt!=N-1 or out_cnt reaching N-1 without m_tlast:
//    set err_len, go SEND anyway (after m_tlast, or at N words).
//  - SEND: word i read at ram_raddr=i, latched 1 cycle later into byte shifter; bytes sent
//    [OUT_W-1 -: 8] first. tx_start only when !tx_busy and no pulse in previous 2 cycles
//    (covers UART busy-assert lag). N*OUT_W/8 bytes per frame (6144 at defaults).
//  - start while busy: ignored. start and AUTO_REARM together in IDLE: one frame only.
//  - frame_cnt increments with frame_done.
// CONFIGURATION
//  FFT_SCHED_HDR_EN defined: SEND prefixes each frame with 4 bytes 0xA5,0x5A,
//    frame_cnt[15:8],frame_cnt[7:0] (pre-increment value); same start spacing rules.
//  Undefined: payload bytes only; no header logic synthesised.
// STRUCTURE
//  Shared package fft_pkg: N_POINTS/IN_W/OUT_W defaults, state encoding localparams,
//    header byte constants, CLOG2 helper.
//  Sub-module fft_word_serializer: loads OUT_W word, emits bytes MSB-first under
//    tx_busy/tx_start pacing, reports last_byte. Scheduler owns counters and FSM.
// TESTING
//  1. N=8, FIFO preloaded 0x80..0x87, s_tready=1 -> s_tdata 0x00..0x07, s_tlast on 8th only.
//  2. s_tready toggling 1-of-3, FIFO empty gaps -> FFT receives exactly 8 samples, in order.
//  3. m_tvalid 8 words W0..W7 w/ tlast on W7 -> RAM addr 0..7 written; UART sees 48 bytes,
//     first 6 = W0[47:40]..W0[7:0]; frame_done pulse; frame_cnt=1.
//  4. m_tlast on 5th word -> err_len=1, SEND still runs; next start clears err_len.
//  5. rst asserted in SEND at byte 10 -> outputs 0 next cycle; new start runs clean frame.
//  6. With FFT_SCHED_HDR_EN, frame_cnt=0x0102 -> first bytes A5 5A 01 02 then payload.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants for the ADC->FFT->UART frame scheduler: default sizes, state
// encoding, frame header bytes and a constant log2 helper.
package fft_pkg;

    localparam int N_POINTS_DEF = 1024;
    localparam int IN_W_DEF     = 8;
    localparam int OUT_W_DEF    = 48;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_FEED_ENC  = 2'd1;
    localparam logic [1:0] ST_STORE_ENC = 2'd2;
    localparam logic [1:0] ST_SEND_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_FEED  = ST_FEED_ENC,
        ST_STORE = ST_STORE_ENC,
        ST_SEND  = ST_SEND_ENC
    } sched_state_t;

    localparam logic [7:0] HDR_SYNC0 = 8'hA5;
    localparam logic [7:0] HDR_SYNC1 = 8'h5A;

    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/fft_word_serializer.sv
// Loads one word and emits its top nbytes bytes MSB-first as UART send pulses,
// keeping two idle cycles after each pulse so a lagging tx_busy is never missed.
module fft_word_serializer #(
    parameter int W     = 48,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     word,
    input  logic [CNT_W-1:0] nbytes,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             empty,
    output logic             last_byte
);

    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] bytes_left;
    logic             start_d1;
    logic             fire;

    assign empty = (bytes_left == '0);
    assign fire  = !empty && !tx_busy && !tx_start && !start_d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bytes_left <= '0;
            start_d1   <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            last_byte  <= 1'b0;
        end else begin
            start_d1  <= tx_start;
            tx_start  <= fire;
            last_byte <= fire && (bytes_left == CNT_W'(1));
            if (load) begin
                shreg      <= word;
                bytes_left <= nbytes;
            end else if (fire) begin
                tx_data    <= shreg[W-1 -: 8];
                shreg      <= shreg << 8;
                bytes_left <= bytes_left - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame sequencer: FIFO -> FFT input stream, FFT output -> result RAM -> UART bytes.
// Define FFT_SCHED_HDR_EN to prefix each UART frame with A5 5A frame_cnt[15:8] frame_cnt[7:0].
module fft_frame_sched
    import fft_pkg::*;
#(
    parameter int N_POINTS   = N_POINTS_DEF,
    parameter int IN_W       = IN_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter bit AUTO_REARM = 1'b0,
    localparam int AW        = CLOG2(N_POINTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [IN_W-1:0]  fifo_rd_data,
    output logic             s_tvalid,
    input  logic             s_tready,
    output logic [IN_W-1:0]  s_tdata,
    output logic             s_tlast,
    input  logic             m_tvalid,
    input  logic [OUT_W-1:0] m_tdata,
    input  logic             m_tlast,
    output logic             ram_we,
    output logic [AW-1:0]    ram_waddr,
    output logic [OUT_W-1:0] ram_wdata,
    output logic [AW-1:0]    ram_raddr,
    input  logic [OUT_W-1:0] ram_rdata,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    output logic             busy,
    output logic             frame_done,
    output logic             err_len,
    output logic [15:0]      frame_cnt
);

`ifdef FFT_SCHED_HDR_EN
    localparam int SER_W = (OUT_W > 32) ? OUT_W : 32;
`else
    localparam int SER_W = OUT_W;
`endif

    sched_state_t     state;
    logic [AW:0]      reads_issued;
    logic [AW-1:0]    arr_cnt;
    logic [AW-1:0]    out_cnt;
    logic [AW:0]      word_cnt;
    logic             rd_pend;
    logic             skid_vld;
    logic [IN_W-1:0]  skid_data;
    logic             skid_last;
    logic             fetch_pend;
    logic             hdr_wait;
    logic             s_take;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             ser_load;
    logic [SER_W-1:0] ser_word;
    logic [7:0]       ser_nbytes;
    logic             ser_empty;
    logic             ser_last;

`ifdef FFT_SCHED_HDR_EN
    logic hdr_pend;
    assign hdr_wait = hdr_pend;
`else
    assign hdr_wait = 1'b0;
`endif

    // The skid slot absorbs the one FIFO word still in flight when the FFT stalls.
    assign fifo_rd_en = (state == ST_FEED) && !fifo_empty && (!s_tvalid || s_tready)
                        && !skid_vld && (reads_issued < (AW+1)'(N_POINTS));
    assign s_take  = s_tvalid && s_tready;
    assign in_data = {~fifo_rd_data[IN_W-1], fifo_rd_data[IN_W-2:0]};
    assign in_last = (arr_cnt == AW'(N_POINTS - 1));

    assign ram_we    = (state == ST_STORE) && m_tvalid;
    assign ram_waddr = out_cnt;
    assign ram_wdata = ram_we ? m_tdata : '0;
    assign ram_raddr = word_cnt[AW-1:0];
    assign busy      = (state != ST_IDLE);

    always_comb begin
        ser_load   = 1'b0;
        ser_word   = SER_W'(ram_rdata) << (SER_W - OUT_W);
        ser_nbytes = 8'(OUT_W / 8);
        if (state == ST_SEND) begin
            if (fetch_pend) begin
                ser_load = 1'b1;
            end
`ifdef FFT_SCHED_HDR_EN
            else if (hdr_pend && ser_empty) begin
                ser_load   = 1'b1;
                ser_word   = SER_W'({HDR_SYNC0, HDR_SYNC1, frame_cnt}) << (SER_W - 32);
                ser_nbytes = 8'd4;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            reads_issued <= '0;
            arr_cnt      <= '0;
            out_cnt      <= '0;
            word_cnt     <= '0;
            rd_pend      <= 1'b0;
            s_tvalid     <= 1'b0;
            s_tdata      <= '0;
            s_tlast      <= 1'b0;
            skid_vld     <= 1'b0;
            skid_data    <= '0;
            skid_last    <= 1'b0;
            fetch_pend   <= 1'b0;
            frame_done   <= 1'b0;
            err_len      <= 1'b0;
            frame_cnt    <= '0;
`ifdef FFT_SCHED_HDR_EN
            hdr_pend     <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            rd_pend    <= fifo_rd_en;
            if (fifo_rd_en) reads_issued <= reads_issued + 1'b1;
            if (rd_pend)    arr_cnt      <= arr_cnt + 1'b1;

            if (!s_tvalid || s_take) begin
                if (skid_vld) begin
                    s_tvalid  <= 1'b1;
                    s_tdata   <= skid_data;
                    s_tlast   <= skid_last;
                    skid_vld  <= rd_pend;
                    skid_data <= in_data;
                    skid_last <= in_last;
                end else if (rd_pend) begin
                    s_tvalid <= 1'b1;
                    s_tdata  <= in_data;
                    s_tlast  <= in_last;
                end else begin
                    s_tvalid <= 1'b0;
                    s_tlast  <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_vld  <= 1'b1;
                skid_data <= in_data;
                skid_last <= in_last;
            end

            case (state)
                ST_IDLE: begin
                    if (start || AUTO_REARM) begin
                        state        <= ST_FEED;
                        reads_issued <= '0;
                        arr_cnt      <= '0;
                        out_cnt      <= '0;
                        if (start) err_len <= 1'b0;
                    end
                end
                ST_FEED: begin
                    if (s_take && s_tlast) state <= ST_STORE;
                end
                ST_STORE: begin
                    if (m_tvalid) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (m_tlast || (out_cnt == AW'(N_POINTS - 1))) begin
                            if (!(m_tlast && (out_cnt == AW'(N_POINTS - 1)))) err_len <= 1'b1;
                            state      <= ST_SEND;
                            word_cnt   <= '0;
                            fetch_pend <= 1'b0;
`ifdef FFT_SCHED_HDR_EN
                            hdr_pend   <= 1'b1;
`endif
                        end
                    end
                end
                ST_SEND: begin
                    // Address is held through fetch_pend so the 1-cycle RAM read lands on load.
                    if (fetch_pend) begin
                        fetch_pend <= 1'b0;
                        word_cnt   <= word_cnt + 1'b1;
                    end else if (ser_empty && !hdr_wait && (word_cnt != (AW+1)'(N_POINTS))) begin
                        fetch_pend <= 1'b1;
                    end
`ifdef FFT_SCHED_HDR_EN
                    if (hdr_pend && ser_empty) hdr_pend <= 1'b0;
`endif
                    if (ser_last && (word_cnt == (AW+1)'(N_POINTS))) begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fft_word_serializer #(
        .W     (SER_W),
        .CNT_W (8)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word      (ser_word),
        .nbytes    (ser_nbytes),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .empty     (ser_empty),
        .last_byte (ser_last)
    );

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched at N=8: FIFO/FFT/RAM/UART models plus hand-computed expectations.
module tb_fft_frame_sched;

    localparam int N     = 8;
    localparam int IN_W  = 8;
    localparam int OUT_W = 48;
    localparam int AW    = 3;
`ifdef FFT_SCHED_HDR_EN
    localparam int HB = 4;
`else
    localparam int HB = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, fifo_empty, fifo_rd_en;
    logic [IN_W-1:0]  fifo_rd_data;
    logic             s_tvalid, s_tready, s_tlast;
    logic [IN_W-1:0]  s_tdata;
    logic             m_tvalid, m_tlast;
    logic [OUT_W-1:0] m_tdata;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [OUT_W-1:0] ram_wdata, ram_rdata;
    logic             tx_start, tx_busy;
    logic [7:0]       tx_data;
    logic             busy, frame_done, err_len;
    logic [15:0]      frame_cnt;

    fft_frame_sched #(
        .N_POINTS   (N),
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .AUTO_REARM (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .s_tlast      (s_tlast),
        .m_tvalid     (m_tvalid),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_len      (err_len),
        .frame_cnt    (frame_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]       fifo_mem [0:255];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic             fifo_gap = 1'b0;
    int               rdy_mode = 0;
    int               cyc = 0;
    logic [7:0]       cap_data [0:255];
    logic             cap_last [0:255];
    int               cap_cnt = 0;
    logic [OUT_W-1:0] ram_mem [0:N-1];
    logic [7:0]       tx_bytes [0:1023];
    int               byte_cnt = 0;
    int               busy_cnt = 0;
    int               ovl_cnt = 0;
    int               done_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr) || fifo_gap;
    assign tx_busy    = (busy_cnt != 0);

    // FIFO, FFT sink, result RAM and UART models
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
        if (s_tvalid && s_tready) begin
            cap_data[cap_cnt[7:0]] <= s_tdata;
            cap_last[cap_cnt[7:0]] <= s_tlast;
            cap_cnt <= cap_cnt + 1;
        end
        if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_raddr];
        if (tx_start) begin
            tx_bytes[byte_cnt[9:0]] <= tx_data;
            byte_cnt <= byte_cnt + 1;
            busy_cnt <= 4;
            if (tx_busy) ovl_cnt <= ovl_cnt + 1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    always @(negedge clk) begin
        s_tready = (rdy_mode == 0) || (cyc % 3 == 0);
        fifo_gap = (rdy_mode != 0) && (cyc % 5 < 2);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] word_of(input int i);
        logic [3:0] n;
        n = 4'(i);
        return {4'hA, n, 4'hB, n, 4'hC, n, 4'hD, n, 4'hE, n, 4'hF, n};
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_feed(input logic [7:0] first);
        int cb, rb;
        cb = cap_cnt;
        rb = rd_ptr;
        for (int i = 0; i < N; i++) push(first + 8'(i));
        pulse_start();
        for (int k = 0; k < 400 && cap_cnt < cb + N; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("feed_count", 64'(cap_cnt - cb), N);
        chk("feed_reads", 64'(rd_ptr - rb), N);
        for (int i = 0; i < N; i++) begin
            chk("feed_data", cap_data[8'(cb + i)], 64'((first + 8'(i)) ^ 8'h80));
            chk("feed_last", cap_last[8'(cb + i)], 64'(i == N - 1));
        end
    endtask

    task automatic drive_out(input int nwords, input int last_at);
        for (int i = 0; i < nwords; i++) begin
            m_tvalid = 1'b1;
            m_tdata  = word_of(i);
            m_tlast  = (i == last_at);
            @(negedge clk);
        end
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
    endtask

    task automatic run_send(input int bb, input logic [15:0] exp_cnt, input logic exp_err,
                            input logic [15:0] hdr_cnt);
        int db, p;
        db = done_cnt;
        for (int k = 0; k < 3000 && done_cnt == db; k++) @(negedge clk);
        chk("frame_done_seen", 64'(done_cnt - db), 1);
        chk("frame_done_pulse", frame_done, 0);
        chk("idle_after_send", busy, 0);
        chk("uart_byte_count", 64'(byte_cnt - bb), N * 6 + HB);
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("err_len_after", err_len, exp_err);
`ifdef FFT_SCHED_HDR_EN
        chk("hdr0", tx_bytes[10'(bb)], 8'hA5);
        chk("hdr1", tx_bytes[10'(bb + 1)], 8'h5A);
        chk("hdr2", tx_bytes[10'(bb + 2)], hdr_cnt[15:8]);
        chk("hdr3", tx_bytes[10'(bb + 3)], hdr_cnt[7:0]);
`else
        if (hdr_cnt != exp_cnt - 16'd1) chk("hdr_cnt_arg", hdr_cnt, exp_cnt - 16'd1);
`endif
        p = bb + HB;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 6; k++)
                chk("uart_payload", tx_bytes[10'(p + 6 * i + k)], {4'(10 + k), 4'(i)});
    endtask

    initial begin
        int bb;
        rst = 1'b1;
        start = 1'b0;
        m_tvalid = 1'b0;
        m_tdata = '0;
        m_tlast = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_s_tvalid", s_tvalid, 0);
        chk("rst_s_tlast", s_tlast, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_raddr", ram_raddr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: preloaded FIFO, FFT always ready, clean output frame
        run_feed(8'h80);
        chk("busy_store", busy, 1);
        bb = byte_cnt;
        drive_out(N, N - 1);
        for (int i = 0; i < N; i++) chk("ram_word", ram_mem[i], word_of(i));
        chk("err_len_clean", err_len, 0);
        run_send(bb, 16'd1, 1'b0, 16'd0);

        // Frame 2: backpressure and FIFO gaps, then early m_tlast on 5th word
        rdy_mode = 1;
        run_feed(8'h10);
        rdy_mode = 0;
        bb = byte_cnt;
        drive_out(5, 4);
        chk("err_len_set", err_len, 1);
        run_send(bb, 16'd2, 1'b1, 16'd1);

        // Frame 3: start clears err_len, reset lands mid-dump
        run_feed(8'h40);
        chk("err_len_clear", err_len, 0);
        bb = byte_cnt;
        drive_out(N, N - 1);
        for (int k = 0; k < 2000 && byte_cnt < bb + 10; k++) @(negedge clk);
        chk("send_progress", 64'(byte_cnt - bb >= 10), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_tx_start", tx_start, 0);
        chk("abort_frame_cnt", frame_cnt, 0);
        chk("abort_s_tvalid", s_tvalid, 0);
        chk("abort_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Frame 4: clean frame after abort
        run_feed(8'h80);
        bb = byte_cnt;
        drive_out(N, N - 1);
        run_send(bb, 16'd1, 1'b0, 16'd0);
        chk("uart_overlap", ovl_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
